trap_unit: RTL
==============

# trap_unit

Parametrised successor to the single-source exception unit. It arbitrates six synchronous exception sources and NUM_IRQ external interrupt lines for the instruction at the E/M boundary. It latches the winning trap, waits for the memory port to drain, and then issues a one-cycle trap pulse with the PC, cause, target and pipeline flushes. It also handles `mret` redirects. It sits between the E/M pipeline latch, the CSR file and the hazard/flush logic.

## Interface
- `NUM_IRQ`, 4: external interrupt lines, 1..16.
- `IRQ_EDGE`, 0: 0 = level-sensitive lines; 1 = rising-edge latched lines.
- `VECTORED_EN`, 1: honour vectored `mtvec` mode for interrupts.

One clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `e2mif_pc` in 32: PC of the instruction in M.
- `e2mif_valid` in 1: M holds a real, non-bubble instruction.
- `inst_misaligned`, `illegal_inst`, `ebreak`, `ecall`, `store_misaligned`, `load_misaligned` in 1 each: exception flags for the M instruction.
- `mret` in 1: M instruction is `mret`.
- `irq_in` in NUM_IRQ: external interrupt requests.
- `irq_en` in NUM_IRQ: per-line enable (mie bits).
- `interrupt_en` in 1: global enable (mstatus.MIE).
- `mtvec` in 32: trap vector CSR.
- `mepc` in 32: return address CSR.
- `mem_busy` in 1: data-memory transaction outstanding.
- `exception` out 1: trap pulse (exception or interrupt).
- `interrupt` out 1: valid with `exception`; 1 = interrupt, 0 = exception.
- `exception_pc`, `exception_cause`, `exception_target` out 32 each: trap PC, cause and target.
- `mret_taken` out 1: return pulse.
- `mret_target` out 32: return address.
- `stall_req` out 1: hold the pipeline while draining.
- `f2dif_flush`, `d2eif_flush`, `e2mif_flush`, `m2wif_flush` out 1 each: pipeline latch flushes.
- `irq_pending` out NUM_IRQ: current pending vector, for mip.

## Operation
- States: IDLE, DRAIN, TRAP, RET.
- Exception candidate: `e2mif_valid` and any flag set.
- Exception priority, with cause codes: `inst_misaligned`(0) > `illegal_inst`(2) > `ebreak`(3) > `ecall`(11) > `store_misaligned`(6) > `load_misaligned`(4).
- Interrupt candidate: `e2mif_valid` & `interrupt_en` & |(`irq_pending` & `irq_en`).
  - Lowest line index wins.
  - Cause = 32'h8000_0000 | (16+i).
- Exceptions beat interrupts. Both beat `mret`.
- IDLE, trap candidate present:
  - Capture `e2mif_pc`, cause and the interrupt flag into holding registers.
  - Go to TRAP if `mem_busy`=0, else DRAIN.
- IDLE, `mret` only: capture `mepc` and go to RET.
- DRAIN:
  - `stall_req`=1.
  - Inputs are ignored; the captured values are held.
  - Go to TRAP on the first cycle with `mem_busy`=0.
- TRAP, one cycle:
  - `exception`=1 and all four flushes =1.
  - Outputs are driven from the holding registers.
  - If the trap was an interrupt in edge mode, clear the winning pending bit.
  - Go to IDLE.
- RET, one cycle:
  - `mret_taken`=1, `mret_target` = captured `mepc`.
  - f2d, d2e and e2m flushes =1; m2w flush =0, so `mret` retires.
  - Go to IDLE.
- Target computation:
  - Base = {`mtvec`[31:2],2'b00}.
  - Interrupt with `VECTORED_EN`=1 and `mtvec`[1:0]=01: target = base + 4*(cause[4:0]), computed in 32 bits with wrap.
  - Otherwise: target = base. Mode values 10 and 11 are treated as direct.
- Pending vector:
  - Level mode: `irq_pending` <= `irq_in` every cycle.
  - Edge mode: set on `irq_in` & ~`irq_in_q`; clear only when that line's trap is taken.
  - Simultaneous set and clear on the same line: set wins.
- Pending bits update in every state. Only arbitration is frozen outside IDLE.

## Timing
- Reset: state IDLE; every output 0; pending, `irq_in_q` and the holding registers 0.
- Reset in DRAIN, TRAP or RET: the state returns to IDLE and no pulse is issued.
- Trap latency: candidate sampled in cycle N, pulse in cycle N+1 when not busy. With drain, the pulse comes one cycle after the first cycle with `mem_busy`=0.
- Pulse width: `exception` and `mret_taken` are exactly 1 cycle. Back-to-back traps are at least 2 cycles apart.
- Level mode: a line asserted in cycle N is visible to arbitration in cycle N+1.
- `interrupt_en` or `irq_en` dropping during DRAIN does not cancel the captured interrupt.
- `e2mif_valid`=0 blocks all candidates, including interrupts.

## Structure
- `common_types_pkg` gains:
  - the `exc_cause_t` constants: EXC_INST_MISALIGNED=0, EXC_ILLEGAL=2, EXC_BREAK=3, EXC_LOAD_MISALIGNED=4, EXC_STORE_MISALIGNED=6, EXC_ECALL_M=11;
  - IRQ_CAUSE_BASE=16;
  - the `trap_state_t` enum.
- `trap_unit_if` extends `exception_unit_if` with the new signals and keeps the `trap_unit` and `tb` modports.
- Sub-module `trap_irq_pending`: per-line edge/level latch plus priority encoder. Outputs the pending vector, a valid bit and the winning index.

## Test plan
- `illegal_inst`=1, `e2mif_pc`=0x100, `mtvec`=0x8000_0001, `mem_busy`=0 -> next cycle `exception`=1, `interrupt`=0, cause=2, pc=0x100, target=0x8000_0000, four flushes high for 1 cycle.
- `irq_in`=4'b0110, `irq_en`=4'hF, `interrupt_en`=1, `mtvec`=0x8000_0001, vectored -> line 1 wins; cause=0x8000_0011, target=0x8000_0044.
- Interrupt taken with `mem_busy` high for 3 cycles -> `stall_req` high for 3 cycles, then the pulse one cycle after `mem_busy` falls, with the captured pc.
- `illegal_inst`, `ecall` and `irq_in`[0] asserted together -> cause=2, `interrupt`=0; the level-mode pending bit stays set.
- `IRQ_EDGE`=1, 1-cycle pulse on `irq_in`[2] while `interrupt_en`=0 -> bit stays pending. Raising `interrupt_en` then traps with cause 0x8000_0012 and clears bit 2.
- `mret` with `mepc`=0x204 -> `mret_taken` next cycle, target=0x204, m2w flush low. Assert `rst` in DRAIN -> no pulse, all outputs 0.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types for the trap path.
//   exc_cause_t    : synchronous exception cause codes (mcause[4:0])
//   IRQ_CAUSE_BASE : cause offset of external interrupt line 0
//   trap_state_t   : trap sequencer states
//   trap_target()  : mtvec base/vectored target computation
package common_types_pkg;

  typedef enum logic [4:0] {
    EXC_INST_MISALIGNED  = 5'd0,
    EXC_ILLEGAL          = 5'd2,
    EXC_BREAK            = 5'd3,
    EXC_LOAD_MISALIGNED  = 5'd4,
    EXC_STORE_MISALIGNED = 5'd6,
    EXC_ECALL_M          = 5'd11
  } exc_cause_t;

  localparam int unsigned IRQ_CAUSE_BASE = 16;

  typedef enum logic [1:0] {
    TS_IDLE,
    TS_DRAIN,
    TS_TRAP,
    TS_RET
  } trap_state_t;

  // Vectored only for interrupts with mode 01; modes 10/11 fall back to direct.
  function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                              input logic [4:0]  code,
                                              input logic        is_irq,
                                              input bit          vec_en);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (vec_en && is_irq && (tvec[1:0] == 2'b01))
      return base + {25'd0, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/trap_irq_pending.sv
// Per-line interrupt pending latch (level or rising-edge) and lowest-index
// priority encoder over the enabled pending lines.
//   i_irq_in   : raw interrupt lines
//   i_irq_en   : per-line enables
//   i_clr      : clear request for line i_clr_idx (edge mode only)
//   o_pending  : registered pending vector
//   o_valid    : some enabled line pending
//   o_idx      : lowest enabled pending line
module trap_irq_pending
  import common_types_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = 4,
  parameter bit          IRQ_EDGE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] i_irq_in,
  input  logic [NUM_IRQ-1:0] i_irq_en,
  input  logic               i_clr,
  input  logic [3:0]         i_clr_idx,
  output logic [NUM_IRQ-1:0] o_pending,
  output logic               o_valid,
  output logic [3:0]         o_idx
);

  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] w_clr_mask;
  logic [NUM_IRQ-1:0] w_masked;

  always_comb begin
    w_clr_mask = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++)
      if (i_clr && (i_clr_idx == 4'(i))) w_clr_mask[i] = 1'b1;
  end

  assign w_masked = r_pending & i_irq_en;

  // Scan from the top down so the lowest index is the last assignment.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      if (w_masked[NUM_IRQ-1-k]) begin
        o_valid = 1'b1;
        o_idx   = 4'(NUM_IRQ-1-k);
      end
    end
  end

  // Edge mode: a new rising edge on a line being cleared keeps it pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_irq_q   <= '0;
    end else begin
      r_irq_q <= i_irq_in;
      if (IRQ_EDGE)
        r_pending <= (r_pending & ~w_clr_mask) | (i_irq_in & ~r_irq_q);
      else
        r_pending <= i_irq_in;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/trap_unit.sv
// Trap sequencer at the E/M boundary: arbitrates synchronous exceptions and
// external interrupts, drains the memory port, then issues a one-cycle trap
// pulse with pc/cause/target and flushes; also sequences mret redirects.
//   inputs : e2mif_pc/valid, six exception flags, mret, irq_in/irq_en,
//            interrupt_en, mtvec, mepc, mem_busy
//   outputs: exception/interrupt pulse with pc/cause/target, mret_taken/target,
//            stall_req, four pipeline flushes, irq_pending (for mip)
module trap_unit
  import common_types_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 4,
  parameter bit          IRQ_EDGE    = 1'b0,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        e2mif_pc,
  input  logic               e2mif_valid,
  input  logic               inst_misaligned,
  input  logic               illegal_inst,
  input  logic               ebreak,
  input  logic               ecall,
  input  logic               store_misaligned,
  input  logic               load_misaligned,
  input  logic               mret,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               interrupt_en,
  input  logic [31:0]        mtvec,
  input  logic [31:0]        mepc,
  input  logic               mem_busy,
  output logic               exception,
  output logic               interrupt,
  output logic [31:0]        exception_pc,
  output logic [31:0]        exception_cause,
  output logic [31:0]        exception_target,
  output logic               mret_taken,
  output logic [31:0]        mret_target,
  output logic               stall_req,
  output logic               f2dif_flush,
  output logic               d2eif_flush,
  output logic               e2mif_flush,
  output logic               m2wif_flush,
  output logic [NUM_IRQ-1:0] irq_pending
);

  trap_state_t r_state;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic        r_intr;
  logic [3:0]  r_idx;

  logic        w_irq_valid;
  logic [3:0]  w_irq_idx;
  logic        w_exc_any;
  exc_cause_t  w_exc_cause;
  logic        w_irq_cand;
  logic        w_trap_cand;
  logic [31:0] w_cand_cause;
  logic [31:0] w_iss_pc;
  logic [31:0] w_iss_cause;
  logic        w_iss_intr;
  logic [31:0] w_iss_target;

  trap_irq_pending #(
    .NUM_IRQ (NUM_IRQ),
    .IRQ_EDGE(IRQ_EDGE)
  ) u_pending (
    .clk      (clk),
    .rst      (rst),
    .i_irq_in (irq_in),
    .i_irq_en (irq_en),
    .i_clr    ((r_state == TS_TRAP) && r_intr),
    .i_clr_idx(r_idx),
    .o_pending(irq_pending),
    .o_valid  (w_irq_valid),
    .o_idx    (w_irq_idx)
  );

  assign w_exc_any = e2mif_valid & (inst_misaligned | illegal_inst | ebreak |
                                    ecall | store_misaligned | load_misaligned);

  always_comb begin
    w_exc_cause = EXC_INST_MISALIGNED;
    if (inst_misaligned)       w_exc_cause = EXC_INST_MISALIGNED;
    else if (illegal_inst)     w_exc_cause = EXC_ILLEGAL;
    else if (ebreak)           w_exc_cause = EXC_BREAK;
    else if (ecall)            w_exc_cause = EXC_ECALL_M;
    else if (store_misaligned) w_exc_cause = EXC_STORE_MISALIGNED;
    else if (load_misaligned)  w_exc_cause = EXC_LOAD_MISALIGNED;
  end

  assign w_irq_cand   = e2mif_valid & interrupt_en & w_irq_valid;
  assign w_trap_cand  = w_exc_any | w_irq_cand;
  assign w_cand_cause = w_exc_any ? {27'd0, w_exc_cause}
                                  : (32'h8000_0000 | (IRQ_CAUSE_BASE + 32'(w_irq_idx)));

  // A trap issues either straight from IDLE (live candidate) or from DRAIN
  // (held values); the target always uses the current mtvec.
  assign w_iss_pc     = (r_state == TS_DRAIN) ? r_pc    : e2mif_pc;
  assign w_iss_cause  = (r_state == TS_DRAIN) ? r_cause : w_cand_cause;
  assign w_iss_intr   = (r_state == TS_DRAIN) ? r_intr  : ~w_exc_any;
  assign w_iss_target = trap_target(mtvec, w_iss_cause[4:0], w_iss_intr, VECTORED_EN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= TS_IDLE;
      r_pc             <= '0;
      r_cause          <= '0;
      r_intr           <= 1'b0;
      r_idx            <= '0;
      exception        <= 1'b0;
      interrupt        <= 1'b0;
      exception_pc     <= '0;
      exception_cause  <= '0;
      exception_target <= '0;
      mret_taken       <= 1'b0;
      mret_target      <= '0;
      stall_req        <= 1'b0;
      f2dif_flush      <= 1'b0;
      d2eif_flush      <= 1'b0;
      e2mif_flush      <= 1'b0;
      m2wif_flush      <= 1'b0;
    end else begin
      exception        <= 1'b0;
      interrupt        <= 1'b0;
      exception_pc     <= '0;
      exception_cause  <= '0;
      exception_target <= '0;
      mret_taken       <= 1'b0;
      mret_target      <= '0;
      stall_req        <= 1'b0;
      f2dif_flush      <= 1'b0;
      d2eif_flush      <= 1'b0;
      e2mif_flush      <= 1'b0;
      m2wif_flush      <= 1'b0;
      case (r_state)
        TS_IDLE: begin
          if (w_trap_cand) begin
            r_pc    <= e2mif_pc;
            r_cause <= w_cand_cause;
            r_intr  <= ~w_exc_any;
            r_idx   <= w_irq_idx;
          end else if (e2mif_valid && mret) begin
            r_state     <= TS_RET;
            mret_taken  <= 1'b1;
            mret_target <= mepc;
            f2dif_flush <= 1'b1;
            d2eif_flush <= 1'b1;
            e2mif_flush <= 1'b1;
          end
        end
        TS_DRAIN: ;
        default: r_state <= TS_IDLE;
      endcase
      if ((r_state == TS_IDLE && w_trap_cand) || r_state == TS_DRAIN) begin
        if (mem_busy) begin
          r_state   <= TS_DRAIN;
          stall_req <= 1'b1;
        end else begin
          r_state          <= TS_TRAP;
          exception        <= 1'b1;
          interrupt        <= w_iss_intr;
          exception_pc     <= w_iss_pc;
          exception_cause  <= w_iss_cause;
          exception_target <= w_iss_target;
          f2dif_flush      <= 1'b1;
          d2eif_flush      <= 1'b1;
          e2mif_flush      <= 1'b1;
          m2wif_flush      <= 1'b1;
        end
      end
    end
  end

endmodule
